// File: rtl/conv3x3_stream_pkg.sv
// rtl/conv3x3_stream_pkg.sv - shared types and constants for the 3x3 convolution engine
package conv_pkg;

    localparam int KERNEL_TAPS = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Nine full-scale products need four guard bits; one more keeps the sum signed.
    function automatic int acc_w(input int data_width, input int coef_width);
        return data_width + coef_width + 5;
    endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// rtl/conv3x3_stream_if.sv - kernel load, pixel stream and status bundle
interface conv3x3_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8
);
    logic                  k_we;
    logic [3:0]            k_addr;
    logic [COEF_WIDTH-1:0] k_data;
    logic                  valid_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] pixel_IN;
    logic                  valid_out;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] pixel_OUT;
    logic                  busy;
    logic                  frame_done;

    modport slave (
        input  k_we, k_addr, k_data, valid_in, pixel_IN, ready_out,
        output ready_in, valid_out, pixel_OUT, busy, frame_done
    );

    modport master (
        output k_we, k_addr, k_data, valid_in, pixel_IN, ready_out,
        input  ready_in, valid_out, pixel_OUT, busy, frame_done
    );
endinterface

// File: rtl/conv3x3_stream_line_buffer.sv
// rtl/conv3x3_stream_line_buffer.sv - enable-gated shift delay of DEPTH entries
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 28
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Shift one slot per accepted pixel; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_data = r_mem[DEPTH-1];
endmodule

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 signed-kernel convolution with clamp and backpressure
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int SHIFT      = 0
) (
    input  logic            clk,
    input  logic            reset,
    conv3x3_stream_if.slave bus
);
    localparam int ACC_W  = acc_w(DATA_WIDTH, COEF_WIDTH);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_WIDTH) - 1);

    state_t                       r_state, w_state_nxt;
    logic [COL_W-1:0]             r_col;
    logic [ROW_W-1:0]             r_row;
    logic signed [COEF_WIDTH-1:0] r_kern [KERNEL_TAPS];
    logic [DATA_WIDTH-1:0]        r_win [3][3];
    logic                         r_win_v, r_v1, r_v2, r_valid_out;
    logic signed [PROD_W-1:0]     r_prod [KERNEL_TAPS];
    logic signed [ACC_W-1:0]      r_acc;
    logic [DATA_WIDTH-1:0]        r_pix_out;

    logic                         w_stall, w_ready_in, w_in_xfer, w_out_xfer;
    logic                         w_last_in, w_last_out, w_k_wr, w_win_ok;
    logic [DATA_WIDTH-1:0]        w_lb1, w_lb2;
    logic signed [PROD_W-1:0]     w_prod [KERNEL_TAPS];
    logic signed [ACC_W-1:0]      w_sum, w_shifted;
    logic [DATA_WIDTH-1:0]        w_clamped;

    assign w_stall    = r_valid_out & ~bus.ready_out;
    assign w_ready_in = ~w_stall & (r_state != DRAIN);
    assign w_in_xfer  = bus.valid_in & w_ready_in;
    assign w_out_xfer = r_valid_out & bus.ready_out;
    assign w_last_in  = w_in_xfer & (r_row == ROW_LAST) & (r_col == COL_LAST);
    // The last result leaves when nothing valid remains behind it in the pipe.
    assign w_last_out = (r_state == DRAIN) & w_out_xfer & ~r_win_v & ~r_v1 & ~r_v2;
    // A write racing the first pixel of a frame loses: the frame owns the kernel from then on.
    assign w_k_wr     = bus.k_we & (r_state == IDLE) & ~w_in_xfer & (bus.k_addr <= 4'd8);
    assign w_win_ok   = (r_row >= ROW_TWO) & (r_col >= COL_TWO);

    // Next-state logic for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_in_xfer)  w_state_nxt = RUN;
            RUN:     if (w_last_in)  w_state_nxt = DRAIN;
            DRAIN:   if (w_last_out) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and raster position counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_xfer) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Kernel coefficient registers, writable only between frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                r_kern[i] <= '0;
            end
        end else if (w_k_wr) begin
            r_kern[bus.k_addr] <= $signed(bus.k_data);
        end
    end

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .i_en   (w_in_xfer),
        .i_data (bus.pixel_IN),
        .o_data (w_lb1)
    );

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb2 (
        .clk    (clk),
        .i_en   (w_in_xfer),
        .i_data (w_lb1),
        .o_data (w_lb2)
    );

    // Slide the 3x3 window left by one column; newest column enters on the right.
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb2;
            r_win[1][2] <= w_lb1;
            r_win[2][2] <= bus.pixel_IN;
        end
    end

    // Products: unsigned pixel widened with a zero sign bit times sign-extended coefficient.
    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            w_prod[k] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_prod[i*3+j] = PROD_W'(r_win[i][j]) * PROD_W'(r_kern[i*3+j]);
            end
        end
    end

    // Sum the registered products at full accumulator width.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            w_sum = w_sum + ACC_W'(r_prod[k]);
        end
    end

    assign w_shifted = r_acc >>> SHIFT;

    // Clamp the scaled accumulator into the unsigned pixel range.
    always_comb begin
        w_clamped = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted[ACC_W-1]) begin
            w_clamped = '0;
        end else if (w_shifted > PIX_MAX) begin
            w_clamped = '1;
        end
    end

    // Product and accumulator stages; frozen with the rest of the pipe on a stall.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_prod[k] <= w_prod[k];
            end
            r_acc <= w_sum;
        end
    end

    // Valid tags travel with the data; the output register holds while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_v     <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_valid_out <= 1'b0;
            r_pix_out   <= '0;
        end else if (!w_stall) begin
            r_win_v     <= w_in_xfer & w_win_ok;
            r_v1        <= r_win_v;
            r_v2        <= r_v1;
            r_valid_out <= r_v2;
            if (r_v2) begin
                r_pix_out <= w_clamped;
            end
        end
    end

    assign bus.ready_in   = w_ready_in;
    assign bus.valid_out  = r_valid_out;
    assign bus.pixel_OUT  = r_pix_out;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = w_last_out;
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - scoreboard bench for conv3x3_stream on a 5x5 frame
module tb_conv3x3_stream;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int W  = 5;
    localparam int H  = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv3x3_stream_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW)) bus ();

    conv3x3_stream #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .IMG_W(W), .IMG_H(H), .SHIFT(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int sb[$];
    int n_done = 0;
    int n_out = 0;
    int n_stall = 0;
    logic stall_en = 1'b0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] held = '0;

    int exp1[9]   = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
    int exp255[9] = '{default: 255};
    int exp0[9]   = '{default: 0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every output transfer; watch stall stability.
    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                check("stall_valid_held", int'(bus.valid_out), 1);
                check("stall_pixel_held", int'(bus.pixel_OUT), int'(held));
            end
            if (bus.valid_out && !bus.ready_out) begin
                check("stall_ready_in_low", int'(bus.ready_in), 0);
                stall_prev = 1'b1;
                held = bus.pixel_OUT;
                n_stall++;
            end else begin
                stall_prev = 1'b0;
            end
            if (bus.valid_out && bus.ready_out) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_output: got %0d with nothing expected", bus.pixel_OUT);
                end else begin
                    check("pixel_out", int'(bus.pixel_OUT), sb.pop_front());
                end
            end
            if (bus.frame_done) n_done++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Backpressure: ten cycles of ready_out=0 once a frame's outputs are flowing.
    initial begin
        bus.ready_out = 1'b1;
        wait (stall_en && n_out >= 2);
        @(posedge clk);
        #1 bus.ready_out = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.ready_out = 1'b1;
    end

    task automatic push_exp(input int vals[9]);
        foreach (vals[i]) sb.push_back(vals[i]);
    endtask

    task automatic kwrite(input int a, input int d);
        bus.k_we   = 1'b1;
        bus.k_addr = 4'(a);
        bus.k_data = 8'(d);
        @(negedge clk);
        bus.k_we   = 1'b0;
    endtask

    task automatic load_kernel(input int rest, input int center);
        for (int a = 0; a < 9; a++) kwrite(a, (a == 4) ? center : rest);
    endtask

    // mode 0: pixel = 5r+c, mode 1: all 255; stop_at aborts before that index; kw_at raises k_we.
    task automatic send_frame(input int mode, input int stop_at, input int kw_at);
        int budget;
        for (int idx = 0; idx < W * H; idx++) begin
            if (idx == stop_at) begin
                bus.valid_in = 1'b0;
                return;
            end
            if (idx == kw_at) begin
                bus.k_we   = 1'b1;
                bus.k_addr = 4'd4;
                bus.k_data = 8'd7;
            end
            bus.valid_in = 1'b1;
            bus.pixel_IN = (mode == 0) ? 8'(5 * (idx / W) + (idx % W)) : 8'd255;
            #1;
            budget = 0;
            while (!bus.ready_in && budget < 100) begin
                @(negedge clk);
                #1;
                budget++;
            end
            if (budget >= 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL ready_in_timeout: pixel %0d not accepted in 100 cycles", idx);
                bus.valid_in = 1'b0;
                bus.k_we = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
            bus.k_we = 1'b0;
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic finish_frame(input int exp_done);
        int budget = 0;
        while ((sb.size() != 0 || bus.busy) && budget < 200) begin
            @(negedge clk);
            #2;
            budget++;
        end
        check("frame_drained_timeout", (budget >= 200) ? 1 : 0, 0);
        check("pending_expected", sb.size(), 0);
        check("frame_done_count", n_done, exp_done);
        sb.delete();
        n_done = 0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_in = 1'b0;
        bus.pixel_IN = '0;
        bus.k_we     = 1'b0;
        bus.k_addr   = '0;
        bus.k_data   = '0;
        #3;
        check("rst_ready_in", int'(bus.ready_in), 1);
        check("rst_valid_out", int'(bus.valid_out), 0);
        check("rst_pixel_out", int'(bus.pixel_OUT), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // Test 1: all-ones kernel, ramp image
        load_kernel(1, 1);
        push_exp(exp1);
        send_frame(0, -1, -1);
        finish_frame(1);

        // Test 2: saturation
        push_exp(exp255);
        send_frame(1, -1, -1);
        finish_frame(1);

        // Test 3: negative clamp; out-of-range address write is dropped
        load_kernel(0, -1);
        kwrite(15, 1);
        push_exp(exp0);
        send_frame(0, -1, -1);
        finish_frame(1);
        push_exp(exp0);
        send_frame(1, -1, -1);
        finish_frame(1);

        // Test 4: backpressure mid-frame
        load_kernel(1, 1);
        n_out = 0;
        n_stall = 0;
        stall_en = 1'b1;
        push_exp(exp1);
        send_frame(0, -1, -1);
        finish_frame(1);
        stall_en = 1'b0;
        check("stall_seen", (n_stall > 0) ? 1 : 0, 1);

        // Test 5: reset during row 3
        push_exp(exp1);
        send_frame(0, 17, -1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid_out", int'(bus.valid_out), 0);
        check("mid_rst_pixel_out", int'(bus.pixel_OUT), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_ready_in", int'(bus.ready_in), 1);
        sb.delete();
        n_done = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        push_exp(exp0);
        send_frame(0, -1, -1);
        finish_frame(1);
        load_kernel(1, 1);
        push_exp(exp1);
        send_frame(0, -1, -1);
        finish_frame(1);

        // Test 6: kernel writes while busy and on the first transfer are ignored
        push_exp(exp1);
        send_frame(0, -1, 7);
        finish_frame(1);
        push_exp(exp1);
        send_frame(0, -1, 0);
        finish_frame(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
